// File: rtl/sram_dump_pkg.sv
// Shared types and constants for the SRAM dump reader: FSM states, word geometry
// and the byte-lane selector used by the serializer.
package sram_dump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    SEND,
    FIN
  } state_e;

  localparam int unsigned BYTES_PER_WORD = 4;

  localparam int unsigned LANE0_MSB = 31;
  localparam int unsigned LANE1_MSB = 23;
  localparam int unsigned LANE2_MSB = 15;
  localparam int unsigned LANE3_MSB = 7;

  typedef logic [1:0] byte_idx_t;

  localparam byte_idx_t LAST_IDX = byte_idx_t'(BYTES_PER_WORD - 1);

  // Index 0 is lane 0 (MSB); bytes leave the block MSB-first.
  function automatic logic [7:0] lane_byte(input logic [31:0] word, input byte_idx_t idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[LANE0_MSB -: 8];
      2'd1:    b = word[LANE1_MSB -: 8];
      2'd2:    b = word[LANE2_MSB -: 8];
      default: b = word[LANE3_MSB -: 8];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sram_dump_ser.sv
// Single-entry word buffer that emits its four bytes MSB-first over valid/ready
// and flags the handshake of the final byte to the controlling FSM.
module sram_dump_ser
  import sram_dump_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic [31:0] word_i,
  input  logic        tx_rdy_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_vld_o,
  output logic        last_acc_o
);

  logic [31:0] word_q;
  byte_idx_t   idx_q;
  logic        vld_q;
  logic [7:0]  data_q;
  byte_idx_t   idx_inc;
  logic        acc;

  assign acc     = vld_q & tx_rdy_i;
  assign idx_inc = idx_q + 2'd1;

  // Flush outranks load so an abort in the capture cycle never raises valid.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      word_q <= '0;
      idx_q  <= '0;
      vld_q  <= 1'b0;
      data_q <= '0;
    end else if (flush_i) begin
      idx_q <= '0;
      vld_q <= 1'b0;
    end else if (load_i) begin
      word_q <= word_i;
      idx_q  <= '0;
      vld_q  <= 1'b1;
      data_q <= lane_byte(word_i, 2'd0);
    end else if (acc) begin
      idx_q  <= idx_inc;
      data_q <= lane_byte(word_q, idx_inc);
      if (idx_q == LAST_IDX) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign tx_data_o  = data_q;
  assign tx_vld_o   = vld_q;
  assign last_acc_o = acc & (idx_q == LAST_IDX);

endmodule

// File: rtl/sram_dump_reader.sv
// Streams a window of 32-bit SRAM words out as bytes; owns the SRAM read port
// only while busy and reads one word at a time into a single-entry buffer.
module sram_dump_reader
  import sram_dump_pkg::*;
#(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              hclk,
  input  logic              hrst_b,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W:0]   word_cnt_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              sram_cen_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  input  logic [31:0]       sram_rdata_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_vld_o,
  input  logic              tx_rdy_i
);

  localparam logic [1:0]    LAT_LAST = 2'(RD_LAT - 1);
  localparam logic [ADDR_W:0] ONE_WORD = (ADDR_W + 1)'(1);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   rem_q;
  logic [1:0]        lat_q;
  logic              busy_q;
  logic              done_q;
  logic              cen_q;

  logic              ser_load;
  logic              ser_flush;
  logic              last_acc;

  assign ser_load  = (state_q == WAIT) && (lat_q == LAT_LAST);
  assign ser_flush = abort_i && (state_q != IDLE);

  sram_dump_ser u_ser (
    .clk_i      (hclk),
    .rst_ni     (hrst_b),
    .load_i     (ser_load),
    .flush_i    (ser_flush),
    .word_i     (sram_rdata_i),
    .tx_rdy_i   (tx_rdy_i),
    .tx_data_o  (tx_data_o),
    .tx_vld_o   (tx_vld_o),
    .last_acc_o (last_acc)
  );

  // cen is registered and asserted on the edge entering RD, so it is low for RD only.
  always_ff @(posedge hclk) begin
    if (!hrst_b) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      lat_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cen_q   <= 1'b1;
    end else if (abort_i && (state_q != IDLE)) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cen_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            busy_q <= 1'b1;
            if (word_cnt_i != '0) begin
              addr_q  <= base_addr_i;
              rem_q   <= word_cnt_i;
              cen_q   <= 1'b0;
              state_q <= RD;
            end else begin
              done_q  <= 1'b1;
              state_q <= FIN;
            end
          end
        end
        RD: begin
          cen_q   <= 1'b1;
          lat_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (lat_q == LAT_LAST) begin
            state_q <= SEND;
          end else begin
            lat_q <= lat_q + 2'd1;
          end
        end
        SEND: begin
          if (last_acc) begin
            if (rem_q == ONE_WORD) begin
              rem_q   <= '0;
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              addr_q  <= addr_q + 1'b1;
              rem_q   <= rem_q - ONE_WORD;
              cen_q   <= 1'b0;
              state_q <= RD;
            end
          end
        end
        FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          cen_q   <= 1'b1;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign sram_cen_o  = cen_q;
  assign sram_addr_o = addr_q;

endmodule

// File: tb/tb_sram_dump_reader.sv
// Directed bench: two instances (RD_LAT 1 and 2) share one SRAM image; a queue
// model of expected reads/bytes is checked every cycle, plus literal test checks.
module tb_sram_dump_reader;

  localparam int unsigned AW = 14;
  localparam int NI = 2;
  localparam int P_IDLE = 0;
  localparam int P_ACT  = 1;
  localparam int P_FIN  = 2;

  logic hclk = 1'b0;
  always #5 hclk = ~hclk;

  logic          rstb  [NI];
  logic          start [NI];
  logic          abort [NI];
  logic          rdy   [NI];
  logic [AW-1:0] base  [NI];
  logic [AW:0]   cnt   [NI];
  logic          busy  [NI];
  logic          done  [NI];
  logic          cen   [NI];
  logic [AW-1:0] saddr [NI];
  logic [7:0]    txd   [NI];
  logic          vld   [NI];

  logic [31:0] mem [0:(1<<AW)-1];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [31:0] p1, p2, rd;
    always @(posedge hclk) begin
      if (!cen[g]) p1 <= mem[saddr[g]];
      p2 <= p1;
    end
    assign rd = (g == 0) ? p1 : p2;

    sram_dump_reader #(.ADDR_W(AW), .RD_LAT(g + 1)) u_dut (
      .hclk         (hclk),
      .hrst_b       (rstb[g]),
      .start_i      (start[g]),
      .abort_i      (abort[g]),
      .base_addr_i  (base[g]),
      .word_cnt_i   (cnt[g]),
      .busy_o       (busy[g]),
      .done_o       (done[g]),
      .sram_cen_o   (cen[g]),
      .sram_addr_o  (saddr[g]),
      .sram_rdata_i (rd),
      .tx_data_o    (txd[g]),
      .tx_vld_o     (vld[g]),
      .tx_rdy_i     (rdy[g])
    );
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [AW-1:0] exp_addr [NI][$];
  logic [7:0]    exp_byte [NI][$];
  logic [AW-1:0] got_addr [NI][$];
  logic [7:0]    got_byte [NI][$];
  int   phase   [NI];
  int   n_done  [NI];
  int   start_cyc [NI];
  int   done_cyc  [NI];
  int   last_hs_cyc [NI];
  logic chk_rst [NI];
  logic chk_abt [NI];
  logic p_hold  [NI];
  logic [7:0] p_data [NI];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Expected dump: word k is read at (base + k) mod 2**AW, bytes MSB-first.
  task automatic plan(input int i, input logic [AW-1:0] b, input logic [AW:0] n);
    logic [AW-1:0] a;
    logic [31:0]   w;
    for (int k = 0; k < int'(n); k++) begin
      a = AW'((int'(b) + k) % (1 << AW));
      w = mem[a];
      exp_addr[i].push_back(a);
      for (int j = 3; j >= 0; j--) exp_byte[i].push_back(w[j*8 +: 8]);
    end
  endtask

  always @(negedge hclk) begin
    cyc++;
    for (int i = 0; i < NI; i++) begin : per_inst
      logic hs;
      logic [AW-1:0] ea;
      logic [7:0] eb;
      if (!rstb[i]) begin
        exp_addr[i].delete();
        exp_byte[i].delete();
        phase[i]   = P_IDLE;
        chk_rst[i] = 1'b1;
        chk_abt[i] = 1'b0;
        p_hold[i]  = 1'b0;
      end else begin
        if (chk_rst[i]) begin
          chk("rst_busy", 32'(busy[i]), 0);
          chk("rst_done", 32'(done[i]), 0);
          chk("rst_cen",  32'(cen[i]), 1);
          chk("rst_addr", 32'(saddr[i]), 0);
          chk("rst_vld",  32'(vld[i]), 0);
          chk("rst_data", 32'(txd[i]), 0);
          chk_rst[i] = 1'b0;
        end
        if (chk_abt[i]) begin
          chk("abort_vld", 32'(vld[i]), 0);
          chk("abort_cen", 32'(cen[i]), 1);
          chk_abt[i] = 1'b0;
        end
        chk("busy", 32'(busy[i]), 32'(phase[i] != P_IDLE));
        chk("done", 32'(done[i]), 32'(phase[i] == P_FIN));
        if (!cen[i]) begin
          if (exp_addr[i].size() == 0) chk("cen_unexpected", 32'(cen[i]), 1);
          else begin
            ea = exp_addr[i].pop_front();
            chk("rd_addr", 32'(saddr[i]), 32'(ea));
          end
          got_addr[i].push_back(saddr[i]);
        end
        if (p_hold[i]) begin
          chk("hold_vld", 32'(vld[i]), 1);
          chk("hold_data", 32'(txd[i]), 32'(p_data[i]));
        end
        hs = vld[i] & rdy[i];
        if (hs) begin
          if (exp_byte[i].size() == 0) chk("byte_unexpected", 32'(vld[i]), 0);
          else begin
            eb = exp_byte[i].pop_front();
            chk("tx_byte", 32'(txd[i]), 32'(eb));
          end
          got_byte[i].push_back(txd[i]);
          last_hs_cyc[i] = cyc;
        end
        if (done[i]) begin
          n_done[i]++;
          done_cyc[i] = cyc;
        end
        p_hold[i] = vld[i] & ~rdy[i] & ~(abort[i] & (phase[i] != P_IDLE));
        p_data[i] = txd[i];
        case (phase[i])
          P_IDLE: if (start[i]) begin
            plan(i, base[i], cnt[i]);
            start_cyc[i] = cyc;
            phase[i] = (cnt[i] == '0) ? P_FIN : P_ACT;
          end
          P_ACT: if (abort[i]) begin
            exp_addr[i].delete();
            exp_byte[i].delete();
            phase[i] = P_IDLE;
            chk_abt[i] = 1'b1;
          end else if (hs && exp_byte[i].size() == 0) begin
            phase[i] = P_FIN;
          end
          default: phase[i] = P_IDLE;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic go(input int i, input logic [AW-1:0] b, input logic [AW:0] n);
    base[i]  = b;
    cnt[i]   = n;
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i, input int budget);
    int k;
    k = 0;
    while (phase[i] != P_IDLE && k < budget) begin
      tick();
      k++;
    end
    tick();
    chk("idle_timeout", 32'(phase[i] == P_IDLE), 1);
    chk("drain_bytes", 32'(exp_byte[i].size()), 0);
  endtask

  task automatic wait_bytes(input int i, input int n, input int budget);
    int k;
    k = 0;
    while (got_byte[i].size() < n && k < budget) begin
      tick();
      k++;
    end
    chk("bytes_timeout", 32'(got_byte[i].size() >= n), 1);
  endtask

  task automatic wait_addrs(input int i, input int n, input int budget);
    int k;
    k = 0;
    while (got_addr[i].size() < n && k < budget) begin
      tick();
      k++;
    end
    chk("addrs_timeout", 32'(got_addr[i].size() >= n), 1);
  endtask

  task automatic clear_log(input int i);
    got_addr[i].delete();
    got_byte[i].delete();
    n_done[i] = 0;
  endtask

  logic [7:0] t1_exp [8];
  logic [7:0] t5_exp [4];
  logic [AW-1:0] t3_addr [3];
  logic [7:0] lf;
  int k;

  initial begin
    t1_exp  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    t5_exp  = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    t3_addr = '{14'h3FFF, 14'h0000, 14'h0001};
    for (int a = 0; a < (1 << AW); a++) mem[a] = 32'(a) * 32'h0001_0003 ^ 32'hC3A5_5A3C;
    mem[14'h0010] = 32'h1122_3344;
    mem[14'h0011] = 32'hAABB_CCDD;
    mem[14'h0012] = 32'h0102_0304;
    mem[14'h0013] = 32'h0506_0708;
    mem[14'h3FFF] = 32'hF0E1_D2C3;
    mem[14'h0000] = 32'hDEAD_BEEF;
    mem[14'h0001] = 32'hCAFE_F00D;
    for (int i = 0; i < NI; i++) begin
      rstb[i] = 1'b0; start[i] = 1'b0; abort[i] = 1'b0; rdy[i] = 1'b1;
      base[i] = '0; cnt[i] = '0; phase[i] = P_IDLE; n_done[i] = 0;
      chk_rst[i] = 1'b0; chk_abt[i] = 1'b0; p_hold[i] = 1'b0;
      start_cyc[i] = 0; done_cyc[i] = 0; last_hs_cyc[i] = 0;
    end
    repeat (2) tick();
    for (int i = 0; i < NI; i++) rstb[i] = 1'b1;
    repeat (2) tick();

    // T1 on both latencies
    for (int i = 0; i < NI; i++) begin
      clear_log(i);
      go(i, 14'h0010, 15'd2);
      wait_idle(i, 200);
      chk("t1_nbytes", 32'(got_byte[i].size()), 8);
      for (int j = 0; j < 8 && j < got_byte[i].size(); j++) chk("t1_byte", 32'(got_byte[i][j]), 32'(t1_exp[j]));
      chk("t1_nreads", 32'(got_addr[i].size()), 2);
      chk("t1_ndone", 32'(n_done[i]), 1);
      chk("t1_done_after_last", 32'(done_cyc[i] - last_hs_cyc[i]), 1);
      chk("t1_latency", 32'(done_cyc[i] - start_cyc[i]), (i == 0) ? 32'd13 : 32'd15);
    end

    // T2: random backpressure
    clear_log(0);
    lf = 8'hA5;
    go(0, 14'h0010, 15'd2);
    k = 0;
    while (phase[0] != P_IDLE && k < 600) begin
      lf = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
      rdy[0] = lf[0];
      tick();
      k++;
    end
    rdy[0] = 1'b1;
    tick();
    chk("t2_timeout", 32'(phase[0] == P_IDLE), 1);
    chk("t2_nbytes", 32'(got_byte[0].size()), 8);
    for (int j = 0; j < 8 && j < got_byte[0].size(); j++) chk("t2_byte", 32'(got_byte[0][j]), 32'(t1_exp[j]));

    // T3: address wrap
    clear_log(0);
    go(0, 14'h3FFF, 15'd3);
    wait_idle(0, 300);
    chk("t3_nreads", 32'(got_addr[0].size()), 3);
    for (int j = 0; j < 3 && j < got_addr[0].size(); j++) chk("t3_addr", 32'(got_addr[0][j]), 32'(t3_addr[j]));
    chk("t3_nbytes", 32'(got_byte[0].size()), 12);
    chk("t3_ndone", 32'(n_done[0]), 1);

    // T4: zero-length dump
    clear_log(0);
    go(0, 14'h0010, 15'd0);
    wait_idle(0, 20);
    chk("t4_ndone", 32'(n_done[0]), 1);
    chk("t4_nreads", 32'(got_addr[0].size()), 0);
    chk("t4_nbytes", 32'(got_byte[0].size()), 0);
    chk("t4_latency", 32'(done_cyc[0] - start_cyc[0]), 1);

    // T5: abort after 5th byte; the byte in the abort cycle still transfers
    clear_log(0);
    go(0, 14'h0010, 15'd4);
    wait_bytes(0, 5, 100);
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    repeat (6) tick();
    chk("t5_nbytes", 32'(got_byte[0].size()), 6);
    if (got_byte[0].size() >= 6) chk("t5_last_byte", 32'(got_byte[0][5]), 32'h0000_00BB);
    chk("t5_nreads", 32'(got_addr[0].size()), 2);
    chk("t5_ndone", 32'(n_done[0]), 0);
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    tick();
    clear_log(0);
    abort[0] = 1'b1;
    go(0, 14'h0000, 15'd1);
    abort[0] = 1'b0;
    wait_idle(0, 100);
    chk("t5b_nbytes", 32'(got_byte[0].size()), 4);
    for (int j = 0; j < 4 && j < got_byte[0].size(); j++) chk("t5b_byte", 32'(got_byte[0][j]), 32'(t5_exp[j]));
    chk("t5b_ndone", 32'(n_done[0]), 1);

    // T6: reset during WAIT of word 2, then start-while-busy ignored
    clear_log(0);
    go(0, 14'h0010, 15'd2);
    wait_addrs(0, 2, 100);
    rstb[0] = 1'b0;
    tick();
    rstb[0] = 1'b1;
    repeat (4) tick();
    chk("t6_ndone", 32'(n_done[0]), 0);
    chk("t6_nbytes", 32'(got_byte[0].size()), 4);
    clear_log(0);
    go(0, 14'h0010, 15'd2);
    wait_bytes(0, 2, 100);
    go(0, 14'h3FFF, 15'd3);
    wait_idle(0, 200);
    chk("t6_ignored_nbytes", 32'(got_byte[0].size()), 8);
    for (int j = 0; j < 8 && j < got_byte[0].size(); j++) chk("t6_byte", 32'(got_byte[0][j]), 32'(t1_exp[j]));
    chk("t6_ndone", 32'(n_done[0]), 1);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
